// File: rtl/chan_mux_pkg.sv
// Shared types and defaults for the channel mux: mode encoding, default sizes,
// and a one-hot to index helper used on the grant vector.
package chan_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 8;

    // Grant vectors are at most 16 wide; callers zero-extend and truncate the result.
    function automatic logic [3:0] oh2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx |= 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load condition.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int PW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] gnt
);

    localparam logic [NCH-1:0] ONE = NCH'(1);

    logic [NCH-1:0] upper;
    logic [NCH-1:0] masked;

    // Requests at or above ptr win first; otherwise wrap to the lowest request.
    assign upper  = ~((ONE << ptr) - ONE);
    assign masked = req & upper;
    assign gnt    = (|masked) ? (masked & (~masked + ONE)) : (req & (~req + ONE));

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel to one mux, fixed-select or round-robin, with a registered output stage.
// Latency: one cycle from accept to y. Backpressure: y_ready low holds y and drops all d_ready.
// CHAN_MUX_RR_PARITY_EN adds y_par, the registered even parity of y.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*W-1:0]       d,
    input  logic [NCH-1:0]         d_valid,
    output logic [NCH-1:0]         d_ready,
    input  logic                   mode,
    input  logic [$clog2(NCH)-1:0] s,
    output logic [W-1:0]           y,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [$clog2(NCH)-1:0] y_ch
`ifdef CHAN_MUX_RR_PARITY_EN
    ,
    output logic                   y_par
`endif
);

    localparam int SW = $clog2(NCH);

    logic [SW-1:0]  ptr;
    logic [SW-1:0]  ptr_nxt;
    logic [SW-1:0]  gnt_idx;
    logic [NCH-1:0] rr_gnt;
    logic [NCH-1:0] fix_gnt;
    logic [NCH-1:0] gnt;
    logic [W-1:0]   sel_dat;
    logic           rr_mode;
    logic           load;

    assign rr_mode = (mode_e'(mode) == MODE_RR);

    // An out-of-range s simply matches no channel.
    always_comb begin
        fix_gnt = '0;
        for (int i = 0; i < NCH; i++) begin
            fix_gnt[i] = d_valid[i] && (s == SW'(i));
        end
    end

    rr_arbiter #(
        .NCH (NCH),
        .PW  (SW)
    ) u_arb (
        .req (d_valid),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    assign gnt     = rr_mode ? rr_gnt : fix_gnt;
    assign load    = (!y_valid || y_ready) && (|gnt);
    assign d_ready = (load && rst_n) ? gnt : '0;
    assign gnt_idx = SW'(oh2idx(16'(gnt)));
    assign ptr_nxt = (gnt_idx == SW'(NCH - 1)) ? '0 : gnt_idx + SW'(1);

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) sel_dat |= d[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load && rr_mode) begin
            ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
        end else if (load) begin
            y       <= sel_dat;
            y_ch    <= gnt_idx;
            y_valid <= 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

`ifdef CHAN_MUX_RR_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par <= 1'b0;
        end else if (load) begin
            y_par <= ^sel_dat;
        end
    end
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// Scoreboard bench for chan_mux_rr: a 4-channel instance driven cycle by cycle
// against a reference model, plus a 6-channel instance for out-of-range select.
module tb_chan_mux_rr;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH*W-1:0] d;
    logic [NCH-1:0]   d_valid;
    logic [NCH-1:0]   d_ready;
    logic             mode;
    logic [1:0]       s;
    logic [W-1:0]     y;
    logic             y_valid;
    logic             y_ready;
    logic [1:0]       y_ch;

    logic [6*W-1:0]   d6;
    logic [5:0]       d_valid6;
    logic [5:0]       d_ready6;
    logic             mode6;
    logic [2:0]       s6;
    logic [W-1:0]     y6;
    logic             y_valid6;
    logic             y_ready6;
    logic [2:0]       y_ch6;
`ifdef CHAN_MUX_RR_PARITY_EN
    logic             y_par;
    logic             y_par6;
`endif

    always #5 clk = ~clk;

    chan_mux_rr #(.NCH(NCH), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .mode    (mode),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_ch    (y_ch)
`ifdef CHAN_MUX_RR_PARITY_EN
        ,
        .y_par   (y_par)
`endif
    );

    chan_mux_rr #(.NCH(6), .W(W)) dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d6),
        .d_valid (d_valid6),
        .d_ready (d_ready6),
        .mode    (mode6),
        .s       (s6),
        .y       (y6),
        .y_valid (y_valid6),
        .y_ready (y_ready6),
        .y_ch    (y_ch6)
`ifdef CHAN_MUX_RR_PARITY_EN
        ,
        .y_par   (y_par6)
`endif
    );

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] dat;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;
    bit   m_yv  = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of stimulus on the 4-channel instance, checked against the model.
    task automatic step(input logic md, input logic [1:0] sv, input logic [3:0] dv,
                        input logic yr, input int fch = -1, input logic [W-1:0] fdat = '0);
        int   ch;
        bit   ld;
        exp_t e;
        @(negedge clk);
        mode    = md;
        s       = sv;
        d_valid = dv;
        y_ready = yr;
        for (int i = 0; i < NCH; i++) d[i*W +: W] = W'($urandom);
        if (fch >= 0) d[fch*W +: W] = fdat;
        #1;
        ch = -1;
        if (md == 1'b0) begin
            if (dv[sv]) ch = int'(sv);
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (ch < 0 && dv[c]) ch = c;
            end
        end
        ld = (!m_yv || yr) && (ch >= 0);
        check("y_valid", 32'(y_valid), 32'(m_yv));
        if (m_yv && q.size() > 0) begin
            check("y", 32'(y), 32'(q[0].dat));
            check("y_ch", 32'(y_ch), 32'(q[0].ch));
`ifdef CHAN_MUX_RR_PARITY_EN
            check("y_par", 32'(y_par), 32'(^q[0].dat));
`endif
            if (yr) void'(q.pop_front());
        end
        check("d_ready", 32'(d_ready), ld ? (32'd1 << ch) : 32'd0);
        if (ld) begin
            e.ch  = 2'(ch);
            e.dat = d[ch*W +: W];
            q.push_back(e);
        end
        @(posedge clk);
        if (ld) m_yv = 1'b1;
        else if (yr) m_yv = 1'b0;
        if (ld && md) m_ptr = (ch + 1) % NCH;
    endtask

    initial begin
        rst_n    = 1'b0;
        d        = '0;
        d_valid  = 4'b1111;
        mode     = 1'b1;
        s        = '0;
        y_ready  = 1'b1;
        d6       = '0;
        d_valid6 = '0;
        mode6    = 1'b0;
        s6       = '0;
        y_ready6 = 1'b0;
        #1;
        check("rst_y", 32'(y), 32'd0);
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_y_ch", 32'(y_ch), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        @(negedge clk);
        d_valid = '0;
        rst_n   = 1'b1;

        // Fixed select of lane 2
        step(1'b0, 2'd2, 4'b0100, 1'b1, 2, 8'hA5);
        step(1'b0, 2'd2, 4'b0000, 1'b1);
        // Round-robin, all valid, full throughput
        for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 4'b1111, 1'b1);
        // Backpressure for three cycles, then drain and reload together
        step(1'b1, 2'd0, 4'b1111, 1'b0);
        step(1'b1, 2'd0, 4'b1111, 1'b0);
        step(1'b1, 2'd0, 4'b1111, 1'b0);
        step(1'b1, 2'd0, 4'b1111, 1'b1);
        step(1'b1, 2'd0, 4'b0000, 1'b1);
        step(1'b1, 2'd0, 4'b0000, 1'b1);
        // Fixed select of an idle channel yields no grant
        step(1'b0, 2'd1, 4'b1000, 1'b1);
        step(1'b0, 2'd1, 4'b1000, 1'b1);
        // Parity vectors
        step(1'b0, 2'd0, 4'b0001, 1'b1, 0, 8'h07);
        step(1'b0, 2'd0, 4'b0001, 1'b1, 0, 8'h03);
        step(1'b0, 2'd0, 4'b0000, 1'b1);
        // Mixed random traffic with mode and select changes
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom), 2'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        step(1'b1, 2'd0, 4'b0000, 1'b1);
        step(1'b1, 2'd0, 4'b0000, 1'b1);

        // Move ptr off zero, then hold 3C and reset in the middle of the hold
        step(1'b1, 2'd0, 4'b0010, 1'b1);
        step(1'b0, 2'd0, 4'b0000, 1'b1);
        step(1'b0, 2'd0, 4'b0001, 1'b0, 0, 8'h3C);
        step(1'b0, 2'd0, 4'b0001, 1'b0, 0, 8'h3C);
        @(negedge clk);
        y_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_y_valid", 32'(y_valid), 32'd0);
        check("mid_rst_d_ready", 32'(d_ready), 32'd0);
        @(posedge clk);
        #1;
        check("held_rst_y_valid", 32'(y_valid), 32'd0);
        check("held_rst_d_ready", 32'(d_ready), 32'd0);
        q.delete();
        m_yv  = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        d_valid = '0;
        rst_n   = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 4'b1111, 1'b1);
        step(1'b1, 2'd0, 4'b0000, 1'b1);
        step(1'b1, 2'd0, 4'b0000, 1'b1);

        // Six-channel instance: selects 6 and 7 are out of range
        @(negedge clk);
        d6       = 48'h0;
        d6[5*W +: W] = 8'h5A;
        d6[0 +: W]   = 8'hC3;
        d_valid6 = 6'b111111;
        y_ready6 = 1'b1;
        mode6    = 1'b0;
        s6       = 3'd7;
        #1;
        check("d_ready6_s7", 32'(d_ready6), 32'd0);
        @(negedge clk);
        s6 = 3'd6;
        #1;
        check("y_valid6_s7", 32'(y_valid6), 32'd0);
        check("d_ready6_s6", 32'(d_ready6), 32'd0);
        @(negedge clk);
        s6 = 3'd5;
        #1;
        check("y_valid6_s6", 32'(y_valid6), 32'd0);
        check("d_ready6_s5", 32'(d_ready6), 32'h20);
        @(negedge clk);
        mode6 = 1'b1;
        #1;
        check("y6_s5", 32'(y6), 32'h5A);
        check("y_ch6_s5", 32'(y_ch6), 32'd5);
        check("d_ready6_rr", 32'(d_ready6), 32'h01);
        @(negedge clk);
        d_valid6 = '0;
        #1;
        check("y6_rr", 32'(y6), 32'hC3);
        check("y_ch6_rr", 32'(y_ch6), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
